// File: rtl/omem_drain.sv
// -----------------------------------------------------------------------------
// omem_drain
// Output-side drain/accumulate stage of the 4x4 MAC array. Captures the
// diagonally skewed partial-sum rows, de-skews them, and writes or accumulates
// each aligned row into a 16-entry x 4-lane output memory at {base,row}.
// Issues a one-cycle Tile_Done once the four rows of a tile are committed.
//
// Ports:
//   CLK, RSTN      clock, asynchronous active-low reset
//   START_CALC     rising edge (in IDLE) arms a tile
//   ACC            sampled at arm: 1 = accumulate, 0 = overwrite
//   ODST[3:2]      sampled at arm: tile base {m,t}
//   CLR_OMEM       synchronous clear of memory and OVF
//   PSUM_VLD       lane-0 valid of a skewed row
//   PSUM           4 lanes of DW-bit signed partial sums (lane k at k*DW)
//   RD_EN/RD_ADDR  host read strobe/address
//   RD_DATA        registered read data (4 lanes of OW bits)
//   Tile_Done      one-cycle tile completion pulse
//   BUSY           high from arm until Tile_Done
//   OVF            sticky signed-overflow flag
//
// Build option: OMEM_SAT_EN - when defined, overflowing lanes saturate to the
// signed OW-bit max/min instead of wrapping.
// -----------------------------------------------------------------------------
module omem_drain #(
  parameter int DW = 16,
  parameter int OW = 20
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START_CALC,
  input  logic            ACC,
  input  logic [3:0]      ODST,
  input  logic            CLR_OMEM,
  input  logic            PSUM_VLD,
  input  logic [4*DW-1:0] PSUM,
  input  logic            RD_EN,
  input  logic [3:0]      RD_ADDR,
  output logic [4*OW-1:0] RD_DATA,
  output logic            Tile_Done,
  output logic            BUSY,
  output logic            OVF
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_start_d;
  logic              r_acc;
  logic [1:0]        r_base;
  logic [1:0]        r_row;
  logic [3*DW-1:0]   r_l0;
  logic [2*DW-1:0]   r_l1;
  logic [DW-1:0]     r_l2;
  logic [2:0]        r_vld;
  logic [4*OW-1:0]   r_mem [16];
  logic [4*OW-1:0]   r_rd_data;
  logic              r_done;
  logic              r_busy;
  logic              r_ovf;

  logic              w_arm;
  logic              w_wr;
  logic [3:0]        w_addr;
  logic [4*DW-1:0]   w_aligned;
  logic [4*OW-1:0]   w_old;
  logic [4*OW-1:0]   w_wdata;
  logic [OW:0]       w_lane;
  logic              w_ovf;
  logic              w_unused;

  // One lane of write data: returns {overflow, value}. Overwrite never overflows.
  function automatic logic [OW:0] lane_wr(input logic [OW-1:0] old_v,
                                          input logic [DW-1:0] ps,
                                          input logic          acc);
    logic [OW-1:0] ext;
    logic [OW-1:0] sum;
    logic          ovf;
    ext = {{(OW-DW){ps[DW-1]}}, ps};
    if (acc) begin
      sum = old_v + ext;
      // Signed overflow: operands share a sign that the result does not.
      ovf = (old_v[OW-1] == ext[OW-1]) && (sum[OW-1] != old_v[OW-1]);
    end else begin
      sum = ext;
      ovf = 1'b0;
    end
`ifdef OMEM_SAT_EN
    sum = ovf ? (old_v[OW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}}) : sum;
`endif
    return {ovf, sum};
  endfunction

  // Only the tile-base bits of ODST are meaningful here.
  assign w_unused  = ^ODST[1:0];

  assign w_arm     = START_CALC & ~r_start_d;
  assign w_wr      = (r_state == S_DRAIN) & r_vld[2];
  assign w_addr    = {r_base, r_row};
  // Lane k has been delayed 3-k cycles, so all four lanes line up here.
  assign w_aligned = {PSUM[3*DW +: DW], r_l2, r_l1[2*DW-1 -: DW], r_l0[3*DW-1 -: DW]};
  assign w_old     = r_mem[w_addr];

  assign RD_DATA   = r_rd_data;
  assign Tile_Done = r_done;
  assign BUSY      = r_busy;
  assign OVF       = r_ovf;

  // Per-lane write data and combined overflow flag.
  always_comb begin
    w_wdata = '0;
    w_ovf   = 1'b0;
    w_lane  = '0;
    for (int k = 0; k < 4; k++) begin
      w_lane = lane_wr(w_old[k*OW +: OW], w_aligned[k*DW +: DW], r_acc);
      w_wdata[k*OW +: OW] = w_lane[OW-1:0];
      w_ovf = w_ovf | w_lane[OW];
    end
  end

  // Next-state logic for the tile FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_arm) w_next = S_DRAIN;
        else       w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (w_wr && (r_row == 2'd3)) w_next = S_DONE;
        else                         w_next = S_DRAIN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_DRAIN);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Arm capture (edge detect, base, mode) and row counter.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_start_d <= 1'b0;
      r_acc     <= 1'b0;
      r_base    <= 2'd0;
      r_row     <= 2'd0;
    end else begin
      r_start_d <= START_CALC;
      if ((r_state == S_IDLE) && w_arm) begin
        r_base <= ODST[3:2];
        r_acc  <= ACC;
        r_row  <= 2'd0;
      end else if (w_wr) begin
        // Row advances even if a same-cycle clear suppresses the write.
        r_row <= r_row + 2'd1;
      end
    end
  end

  // De-skew delay lines; they run in every state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_l0  <= '0;
      r_l1  <= '0;
      r_l2  <= '0;
      r_vld <= 3'd0;
    end else begin
      r_l0  <= {r_l0[2*DW-1:0], PSUM[0 +: DW]};
      r_l1  <= {r_l1[DW-1:0], PSUM[DW +: DW]};
      r_l2  <= PSUM[2*DW +: DW];
      r_vld <= {r_vld[1:0], PSUM_VLD};
    end
  end

  // Output memory; clear beats a drain write in the same cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (CLR_OMEM) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_ovf <= 1'b0;
    end else if (CLR_OMEM) begin
      r_ovf <= 1'b0;
    end else if (w_wr && w_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  // Host read port; a same-cycle write is not forwarded (old data returned).
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_data <= '0;
    end else if (RD_EN) begin
      r_rd_data <= r_mem[RD_ADDR];
    end
  end

endmodule

// File: doc/omem_drain.md
# omem_drain

Output-side drain and accumulate stage of the 4x4 MAC array. It captures the diagonally skewed partial-sum rows leaving the array and de-skews them. It then writes or accumulates each row into a 16-entry output memory at the tile address supplied by the tile controller, and returns a single-cycle `Tile_Done` pulse to the controller once all four rows of a tile are committed.

## Interface
Parameters:
- `DW`, 16: width of one signed partial-sum lane from the array.
- `OW`, 20: width of one signed output-memory lane.

Ports:
- `CLK`, in, 1: clock.
- `RSTN`, in, 1: reset, asynchronous, active-low.
- `START_CALC`, in, 1: high during controller RUN. The rising edge arms a tile.
- `ACC`, in, 1: sampled at arm. 1 = add to stored value, 0 = overwrite.
- `ODST`, in, 4: `ODST[3:2]` is sampled at arm as the tile base `{m,t}`.
- `CLR_OMEM`, in, 1: synchronous clear of all 16 entries and of `OVF`.
- `PSUM_VLD`, in, 1: lane-0 valid of one result row.
- `PSUM`, in, 4*DW: lane k is `PSUM[k*DW +: DW]`.
- `RD_EN`, in, 1: host read strobe.
- `RD_ADDR`, in, 4: host read address.
- `RD_DATA`, out, 4*OW: registered read data.
- `Tile_Done`, out, 1: 1-cycle pulse.
- `BUSY`, out, 1: high from arm until `Tile_Done`.
- `OVF`, out, 1: sticky overflow flag.

## Operation
- Skew rule: for a row whose `PSUM_VLD` is high at cycle c, lane k is valid on `PSUM` at cycle c+k.
- De-skew: lane k passes through a (3-k)-stage delay line, so the complete row is aligned at c+3. A valid bit travels with lane 0 through a 3-stage delay.
- State machine:
  - IDLE: a `START_CALC` 0→1 transition latches `base=ODST[3:2]` and `acc=ACC`, clears `row=0` and moves to DRAIN.
  - DRAIN: each aligned row writes entry `{base,row}`, then `row++`. Once four rows are written, go to DONE.
  - DONE: assert `Tile_Done` for one cycle and return to IDLE.
- Write data per lane:
  - `acc=1`: `mem[a][k] + sext(psum_k)`.
  - `acc=0`: `sext(psum_k)`.
  - Arithmetic is OW-bit signed.
- Overflow: an OW-bit signed overflow on any lane sets `OVF`. `OVF` clears only on reset or `CLR_OMEM`.
- `PSUM_VLD` in IDLE is ignored (no write) but still propagates through the delay line. A row that aligns while IDLE is dropped.
- A `START_CALC` rising edge while in DRAIN or DONE is ignored.
- Host read: `RD_DATA <= mem[RD_ADDR]` one cycle after `RD_EN`. A read and a write to the same entry in the same cycle returns the old value. `RD_DATA` holds its value when `RD_EN=0`.
- `CLR_OMEM` has priority over a drain write in the same cycle. It does not change state, `row` or the delay lines.
- Reset values: state IDLE, delay lines and valid bits 0, memory 0, `RD_DATA` 0, `Tile_Done` 0, `BUSY` 0, `OVF` 0.
- Reset mid-tile aborts the tile immediately. No `Tile_Done` is issued.

## Timing
- Arm is effective in the cycle after the `START_CALC` rising edge. `BUSY` goes high that cycle.
- Row write latency: `PSUM_VLD` at cycle c results in a memory update at the clock edge ending cycle c+3.
- `Tile_Done` is high in the cycle after the 4th write. `BUSY` drops in the same cycle `Tile_Done` rises.
- Rows may arrive back-to-back, one per cycle. Gaps are allowed. No back-pressure exists.
- Minimum tile spacing is one IDLE cycle between `Tile_Done` and the next arm.

## Configuration
- `OMEM_SAT_EN`:
  - Defined: on overflow the stored lane saturates to the signed OW-bit max or min, and `OVF` is set.
  - Undefined: lanes wrap modulo 2^OW and `OVF` is still set.
  - The write datapath differs only in the final clamp.

## Test plan
- Single tile, overwrite:
  - Stimulus: arm with `ODST=4'b0100`, `ACC=0`. Send rows with lane k of row r = 10r+k, back-to-back.
  - Response: `mem[4..7]` lane k = 10r+k. `Tile_Done` is high exactly 4 cycles after the last `PSUM_VLD`.
- Accumulate:
  - Stimulus: repeat the single-tile test with `ACC=1`, same base, all lanes = 5.
  - Response: each lane = 10r+k+5. `OVF` = 0.
- Overflow:
  - Stimulus: preload a lane to 2^19-1, then accumulate +1.
  - Response with the macro defined: lane reads 2^19-1. Response without it: lane reads -2^19. `OVF` = 1 in both cases.
- Gapped rows:
  - Stimulus: rows at cycles 0, 2, 5, 6.
  - Response: writes at cycles 3, 5, 8, 9. `Tile_Done` at cycle 10.
- Reset and clear:
  - Stimulus: assert `RSTN` low after 2 rows.
  - Response: no `Tile_Done`, memory all 0, `BUSY` 0.
  - Stimulus: `CLR_OMEM` in the same cycle as a write.
  - Response: the entry reads 0.
- Read collision:
  - Stimulus: `RD_EN` at `RD_ADDR=5` in the cycle entry 5 is written.
  - Response: `RD_DATA` returns the pre-write value.
